// File: rtl/comp_reg_tracker_if.sv
// rtl/comp_reg_tracker_if.sv - sample/result bundle between a sample source and comp_reg_tracker
interface comp_reg_tracker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] din_b;
  logic                  clear;
  logic                  out_valid;
  logic                  comp_equal;
  logic                  comp_greater;
  logic                  comp_less;
  logic                  change_flag;
  logic [CNT_WIDTH-1:0]  eq_count;
  logic [CNT_WIDTH-1:0]  gt_count;

  modport master (
    output in_valid, din_a, din_b, clear,
    input  out_valid, comp_equal, comp_greater, comp_less, change_flag, eq_count, gt_count
  );

  modport slave (
    input  in_valid, din_a, din_b, clear,
    output out_valid, comp_equal, comp_greater, comp_less, change_flag, eq_count, gt_count
  );
endinterface

// File: rtl/comp_reg_tracker.sv
// rtl/comp_reg_tracker.sv - registered parametrised magnitude comparator with hold, saturating counters and change flag
module comp_reg_tracker #(
  parameter int DATA_WIDTH  = 8,
  parameter int SIGNED_MODE = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  comp_reg_tracker_if.slave bus
);
  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  logic                 out_valid_q;
  logic                 comp_equal_q;
  logic                 comp_greater_q;
  logic                 comp_less_q;
  logic                 change_flag_q;
  logic                 history_valid;
  logic [1:0]           prev_result;
  logic [1:0]           cur_result;
  logic                 is_eq;
  logic                 is_gt;
  logic [CNT_WIDTH-1:0] eq_count_q;
  logic [CNT_WIDTH-1:0] gt_count_q;
  logic [CNT_WIDTH-1:0] eq_base;
  logic [CNT_WIDTH-1:0] gt_base;

  always_comb begin
    is_eq = (bus.din_a == bus.din_b);
    if (SIGNED_MODE != 0) begin
      is_gt = ($signed(bus.din_a) > $signed(bus.din_b));
    end else begin
      is_gt = (bus.din_a > bus.din_b);
    end
    cur_result = is_eq ? RES_EQ : (is_gt ? RES_GT : RES_LT);
    // clear acts first, so a same-cycle sample counts from zero
    eq_base = bus.clear ? '0 : eq_count_q;
    gt_base = bus.clear ? '0 : gt_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      comp_equal_q   <= 1'b0;
      comp_greater_q <= 1'b0;
      comp_less_q    <= 1'b0;
      change_flag_q  <= 1'b0;
      history_valid  <= 1'b0;
      prev_result    <= RES_EQ;
      eq_count_q     <= '0;
      gt_count_q     <= '0;
    end else begin
      out_valid_q   <= bus.in_valid;
      change_flag_q <= bus.in_valid && history_valid && !bus.clear && (cur_result != prev_result);
      if (bus.in_valid) begin
        comp_equal_q   <= (cur_result == RES_EQ);
        comp_greater_q <= (cur_result == RES_GT);
        comp_less_q    <= (cur_result == RES_LT);
        prev_result    <= cur_result;
        history_valid  <= 1'b1;
      end else if (bus.clear) begin
        history_valid  <= 1'b0;
      end
      eq_count_q <= (bus.in_valid && is_eq && (eq_base != '1)) ? eq_base + CNT_WIDTH'(1) : eq_base;
      gt_count_q <= (bus.in_valid && !is_eq && is_gt && (gt_base != '1)) ? gt_base + CNT_WIDTH'(1) : gt_base;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.comp_equal   = comp_equal_q;
  assign bus.comp_greater = comp_greater_q;
  assign bus.comp_less    = comp_less_q;
  assign bus.change_flag  = change_flag_q;
  assign bus.eq_count     = eq_count_q;
  assign bus.gt_count     = gt_count_q;
endmodule

// File: tb/tb_comp_reg_tracker.sv
// tb/tb_comp_reg_tracker.sv - scoreboard bench for comp_reg_tracker, unsigned/CNT2 and signed/CNT8 instances
module tb_comp_reg_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comp_reg_tracker_if #(.DATA_WIDTH(8), .CNT_WIDTH(2)) if_u ();
  comp_reg_tracker_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) if_s ();

  comp_reg_tracker #(.DATA_WIDTH(8), .SIGNED_MODE(0), .CNT_WIDTH(2)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .bus(if_u.slave));
  comp_reg_tracker #(.DATA_WIDTH(8), .SIGNED_MODE(1), .CNT_WIDTH(8)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s.slave));

  typedef struct {
    logic ov, eq, gt, lt, chg;
    int   eqc, gtc;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference state, index 0 = unsigned/CNT2, 1 = signed/CNT8
  logic       m_eq[2], m_gt[2], m_lt[2], m_hist[2];
  logic [1:0] m_prev[2];
  int         m_eqc[2], m_gtc[2];
  int         m_max[2] = '{3, 255};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_eq[i] = 0; m_gt[i] = 0; m_lt[i] = 0; m_hist[i] = 0;
      m_prev[i] = 2'd0; m_eqc[i] = 0; m_gtc[i] = 0;
    end
    q_u.delete();
    q_s.delete();
  endtask

  task automatic cmp_inst(input string n, input exp_t e, input logic ov, input logic eq,
                          input logic gt, input logic lt, input logic chg,
                          input logic [31:0] eqc, input logic [31:0] gtc);
    chk({n, ".out_valid"}, 32'(ov), 32'(e.ov));
    chk({n, ".comp_equal"}, 32'(eq), 32'(e.eq));
    chk({n, ".comp_greater"}, 32'(gt), 32'(e.gt));
    chk({n, ".comp_less"}, 32'(lt), 32'(e.lt));
    chk({n, ".change_flag"}, 32'(chg), 32'(e.chg));
    chk({n, ".eq_count"}, eqc, e.eqc);
    chk({n, ".gt_count"}, gtc, e.gtc);
  endtask

  task automatic check_pending();
    exp_t e;
    if (q_u.size() > 0) begin
      e = q_u.pop_front();
      cmp_inst("u", e, if_u.out_valid, if_u.comp_equal, if_u.comp_greater, if_u.comp_less,
               if_u.change_flag, 32'(if_u.eq_count), 32'(if_u.gt_count));
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      cmp_inst("s", e, if_s.out_valid, if_s.comp_equal, if_s.comp_greater, if_s.comp_less,
               if_s.change_flag, 32'(if_s.eq_count), 32'(if_s.gt_count));
    end
  endtask

  // at the falling edge: score the previous edge, drive the next sample, predict its outcome
  task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b, input bit clr);
    exp_t e;
    logic g, eqv;
    logic [1:0] code;
    @(negedge clk);
    check_pending();
    if_u.in_valid = v; if_u.din_a = a; if_u.din_b = b; if_u.clear = clr;
    if_s.in_valid = v; if_s.din_a = a; if_s.din_b = b; if_s.clear = clr;
    for (int i = 0; i < 2; i++) begin
      eqv  = (a == b);
      g    = (i == 1) ? ($signed(a) > $signed(b)) : (a > b);
      code = eqv ? 2'd0 : (g ? 2'd1 : 2'd2);
      if (clr) begin
        m_eqc[i] = 0; m_gtc[i] = 0; m_hist[i] = 0;
      end
      e.ov  = v;
      e.chg = v && m_hist[i] && (code != m_prev[i]);
      if (v) begin
        m_eq[i] = eqv; m_gt[i] = !eqv && g; m_lt[i] = !eqv && !g;
        if (eqv && m_eqc[i] < m_max[i]) m_eqc[i]++;
        if (!eqv && g && m_gtc[i] < m_max[i]) m_gtc[i]++;
        m_hist[i] = 1; m_prev[i] = code;
      end
      e.eq = m_eq[i]; e.gt = m_gt[i]; e.lt = m_lt[i];
      e.eqc = m_eqc[i]; e.gtc = m_gtc[i];
      if (i == 0) q_u.push_back(e);
      else q_s.push_back(e);
    end
  endtask

  initial begin
    if_u.in_valid = 0; if_u.din_a = 0; if_u.din_b = 0; if_u.clear = 0;
    if_s.in_valid = 0; if_s.din_a = 0; if_s.din_b = 0; if_s.clear = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    repeat (3) cycle(0, 8'h00, 8'h00, 0);
    cycle(0, 8'h00, 8'h00, 0);
    chk("idle.out_valid", 32'(if_u.out_valid), 0);
    chk("idle.comp_equal", 32'(if_u.comp_equal), 0);
    chk("idle.eq_count", 32'(if_u.eq_count), 0);

    cycle(1, 8'd0, 8'd0, 0);
    cycle(1, 8'd0, 8'd1, 0);
    cycle(1, 8'd1, 8'd0, 0);
    cycle(1, 8'd1, 8'd1, 0);
    cycle(0, 8'd0, 8'd0, 0);
    chk("basic.eq_count", 32'(if_u.eq_count), 2);
    chk("basic.gt_count", 32'(if_u.gt_count), 1);
    chk("basic.change_flag", 32'(if_u.change_flag), 1);

    cycle(1, 8'hFF, 8'h01, 0);
    cycle(0, 8'd0, 8'd0, 0);
    chk("signed.comp_less", 32'(if_s.comp_less), 1);
    chk("unsigned.comp_greater", 32'(if_u.comp_greater), 1);

    cycle(0, 8'd0, 8'd0, 1);
    repeat (5) cycle(1, 8'h2A, 8'h2A, 0);
    repeat (4) cycle(0, 8'd0, 8'd0, 0);
    chk("hold.comp_equal", 32'(if_u.comp_equal), 1);
    chk("hold.out_valid", 32'(if_u.out_valid), 0);
    chk("sat.eq_count", 32'(if_u.eq_count), 3);

    cycle(1, 8'h55, 8'h55, 1);
    cycle(0, 8'd0, 8'd0, 0);
    chk("clr.eq_count", 32'(if_u.eq_count), 1);
    chk("clr.gt_count", 32'(if_u.gt_count), 0);
    chk("clr.change_flag", 32'(if_u.change_flag), 0);
    chk("clr.out_valid", 32'(if_u.out_valid), 1);

    cycle(1, 8'd5, 8'd3, 0);
    cycle(1, 8'd7, 8'd2, 0);
    cycle(0, 8'd0, 8'd0, 0);
    chk("pre_rst.comp_greater", 32'(if_u.comp_greater), 1);
    chk("pre_rst.gt_count", 32'(if_u.gt_count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.comp_greater", 32'(if_u.comp_greater), 0);
    chk("arst.gt_count", 32'(if_u.gt_count), 0);
    chk("arst.s_eq_count", 32'(if_s.eq_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'd3, 8'd3, 0);
    cycle(0, 8'd0, 8'd0, 0);
    chk("post_rst.change_flag", 32'(if_u.change_flag), 0);
    chk("post_rst.eq_count", 32'(if_u.eq_count), 1);

    for (int k = 0; k < 60; k++) begin
      logic [7:0] ra, rb;
      ra = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      cycle($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 9) == 0);
    end
    cycle(0, 8'd0, 8'd0, 0);
    @(negedge clk);
    check_pending();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
